// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: sequences Zicsr read / read-modify-write / write-only accesses on the CSR bus
module csr_access_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_funct3_i,
  input  logic [11:0] req_csr_i,
  input  logic [4:0]  req_rs1_idx_i,
  input  logic [4:0]  req_rd_idx_i,
  input  logic [31:0] req_rs1_data_i,
  output logic [31:0] csr_addr_o,
  output logic        csr_en_read_o,
  output logic        csr_en_write_o,
  output logic [31:0] csr_wdata_o,
  input  logic [31:0] csr_rdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_illegal_o
);
  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_e;
  state_e      state_q, state_d;
  logic [11:0] csr_q;
  logic [1:0]  op_q;
  logic [31:0] src_q, rdata_q, src_req, wval;
  logic        wr_q, ill_q, en_rd_q, en_wr_q;
  logic        accept, rd_req, wr_req, ill_req;
  assign req_ready_o = (state_q == IDLE) && !rst_i;
  assign accept      = req_valid_i && req_ready_o;
  assign rd_req      = !(req_funct3_i[1:0] == 2'b01 && req_rd_idx_i == 5'd0);
  assign wr_req      = (req_funct3_i[1:0] == 2'b01) || (req_rs1_idx_i != 5'd0);
  assign ill_req     = (req_funct3_i[1:0] == 2'b00)
                    || !(req_csr_i inside {12'h301, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h342,
                                           12'h300, 12'h305, 12'h341, 12'h344, 12'h304, 12'hB00,
                                           12'hB80, 12'hB02, 12'hB82, 12'h306})
                    || (wr_req && req_csr_i[11:10] == 2'b11);
  assign src_req     = req_funct3_i[2] ? {27'b0, req_rs1_idx_i} : req_rs1_data_i;
  // rdata_q is cleared on accept, so a skipped read behaves as old == 0
  assign wval        = op_q == 2'b01 ? src_q : op_q == 2'b10 ? (rdata_q | src_q) : (rdata_q & ~src_q);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = !accept ? IDLE : ill_req ? RESP : rd_req ? READ : WRITE;
      READ:    state_d = WAIT;
      WAIT:    state_d = wr_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = rsp_ready_i ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      csr_q   <= '0;
      op_q    <= '0;
      src_q   <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      ill_q   <= 1'b0;
      en_rd_q <= 1'b0;
      en_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      en_rd_q <= state_d == READ;
      en_wr_q <= state_d == WRITE;
      if (accept) begin
        csr_q   <= req_csr_i;
        op_q    <= req_funct3_i[1:0];
        src_q   <= src_req;
        wr_q    <= wr_req;
        ill_q   <= ill_req;
        rdata_q <= '0;
      end else if (state_q == WAIT) begin
        rdata_q <= csr_rdata_i;
      end
    end
  end
  assign csr_addr_o     = {20'b0, csr_q};
  assign csr_en_read_o  = en_rd_q;
  assign csr_en_write_o = en_wr_q;
  assign csr_wdata_o    = en_wr_q ? wval : '0;
  assign rsp_valid_o    = state_q == RESP;
  assign rsp_rdata_o    = rdata_q;
  assign rsp_illegal_o  = ill_q;
endmodule

// File: tb/tb_csr_access_ctrl.sv
// tb_csr_access_ctrl: directed tests of csr_access_ctrl against a behavioural CSR register file
module tb_csr_access_ctrl;
  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic        req_valid_i = 1'b0, req_ready_o;
  logic [2:0]  req_funct3_i = '0;
  logic [11:0] req_csr_i = '0;
  logic [4:0]  req_rs1_idx_i = '0, req_rd_idx_i = '0;
  logic [31:0] req_rs1_data_i = '0;
  logic [31:0] csr_addr_o, csr_wdata_o, csr_rdata_i = '0, rsp_rdata_o;
  logic        csr_en_read_o, csr_en_write_o, rsp_valid_o, rsp_ready_i = 1'b0, rsp_illegal_o;
  logic [31:0] mem [0:4095];
  int          passed = 0, total = 0;
  int          nrd = 0, nwr = 0;
  logic        both = 1'b0;
  logic [31:0] wd_seen = '0, wa_seen = '0;

  csr_access_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_funct3_i(req_funct3_i), .req_csr_i(req_csr_i),
    .req_rs1_idx_i(req_rs1_idx_i), .req_rd_idx_i(req_rd_idx_i), .req_rs1_data_i(req_rs1_data_i),
    .csr_addr_o(csr_addr_o), .csr_en_read_o(csr_en_read_o), .csr_en_write_o(csr_en_write_o),
    .csr_wdata_o(csr_wdata_o), .csr_rdata_i(csr_rdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_illegal_o(rsp_illegal_o)
  );

  always #5 clk_i = ~clk_i;

  // register file: data_out valid the cycle after the en_read edge
  always @(posedge clk_i) begin
    if (csr_en_read_o) csr_rdata_i <= mem[csr_addr_o[11:0]];
    if (csr_en_write_o) mem[csr_addr_o[11:0]] <= csr_wdata_o;
  end

  always @(negedge clk_i) begin
    if (csr_en_read_o) nrd++;
    if (csr_en_write_o) begin
      nwr++;
      wd_seen = csr_wdata_o;
      wa_seen = csr_addr_o;
    end
    if (csr_en_read_o && csr_en_write_o) both = 1'b1;
  end

  // starts at a negedge with the DUT in IDLE, ends at the negedge after the response handshake
  task automatic do_req(input logic [2:0] f3, input logic [11:0] csr, input logic [4:0] rs1,
                        input logic [4:0] rd, input logic [31:0] d, output int lat,
                        output logic [31:0] rdat, output logic ill, output logic post_v,
                        output logic post_r);
    nrd = 0; nwr = 0; both = 1'b0; wd_seen = '0; wa_seen = '0;
    req_valid_i = 1'b1; req_funct3_i = f3; req_csr_i = csr;
    req_rs1_idx_i = rs1; req_rd_idx_i = rd; req_rs1_data_i = d; rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    @(negedge clk_i);
    lat = 1;
    while (!rsp_valid_o && lat < 20) begin
      @(negedge clk_i);
      lat++;
    end
    rdat = rsp_rdata_o;
    ill = rsp_illegal_o;
    @(negedge clk_i);
    post_v = rsp_valid_o;
    post_r = req_ready_o;
  endtask

  task automatic test_reset;
    #12;
    total++; if (req_ready_o !== 1'b0) $display("FAIL rst_ready got %b exp 0", req_ready_o); else passed++;
    total++; if (csr_addr_o !== 32'h0) $display("FAIL rst_addr got %h exp 0", csr_addr_o); else passed++;
    total++; if ({csr_en_read_o, csr_en_write_o} !== 2'b00) $display("FAIL rst_strobes got %b exp 00", {csr_en_read_o, csr_en_write_o}); else passed++;
    total++; if (csr_wdata_o !== 32'h0) $display("FAIL rst_wdata got %h exp 0", csr_wdata_o); else passed++;
    total++; if (rsp_valid_o !== 1'b0) $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid_o); else passed++;
    total++; if ({rsp_rdata_o, rsp_illegal_o} !== 33'h0) $display("FAIL rst_rsp got %h/%b exp 0/0", rsp_rdata_o, rsp_illegal_o); else passed++;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    total++; if (req_ready_o !== 1'b1) $display("FAIL rst_release_ready got %b exp 1", req_ready_o); else passed++;
    @(negedge clk_i);
  endtask

  task automatic test_write_only;
    int lat; logic [31:0] r; logic il, pv, pr;
    do_req(3'b001, 12'h305, 5'd2, 5'd0, 32'h8000_0100, lat, r, il, pv, pr);
    total++; if (lat !== 2) $display("FAIL wo_latency got %0d exp 2", lat); else passed++;
    total++; if (nrd !== 0 || nwr !== 1) $display("FAIL wo_strobes got rd=%0d wr=%0d exp 0/1", nrd, nwr); else passed++;
    total++; if (wd_seen !== 32'h8000_0100) $display("FAIL wo_wdata got %h exp 80000100", wd_seen); else passed++;
    total++; if (wa_seen !== 32'h305) $display("FAIL wo_addr got %h exp 305", wa_seen); else passed++;
    total++; if (r !== 32'h0 || il !== 1'b0) $display("FAIL wo_rsp got %h/%b exp 0/0", r, il); else passed++;
    do_req(3'b010, 12'h305, 5'd0, 5'd1, 32'hFFFF_FFFF, lat, r, il, pv, pr);
    total++; if (r !== 32'h8000_0100) $display("FAIL ro_rdata got %h exp 80000100", r); else passed++;
    total++; if (nwr !== 0 || nrd !== 1 || lat !== 3) $display("FAIL ro_shape got wr=%0d rd=%0d lat=%0d exp 0/1/3", nwr, nrd, lat); else passed++;
  endtask

  task automatic test_rmw_set;
    int lat; logic [31:0] r; logic il, pv, pr;
    do_req(3'b010, 12'h304, 5'd4, 5'd3, 32'h80, lat, r, il, pv, pr);
    total++; if (nrd !== 1 || nwr !== 1) $display("FAIL rs_strobes got rd=%0d wr=%0d exp 1/1", nrd, nwr); else passed++;
    total++; if (wd_seen !== 32'h88) $display("FAIL rs_wdata got %h exp 88", wd_seen); else passed++;
    total++; if (r !== 32'h8) $display("FAIL rs_rdata got %h exp 8", r); else passed++;
    total++; if (lat !== 4) $display("FAIL rs_latency got %0d exp 4", lat); else passed++;
    total++; if (mem[12'h304] !== 32'h88) $display("FAIL rs_regfile got %h exp 88", mem[12'h304]); else passed++;
    total++; if (both !== 1'b0) $display("FAIL rs_overlap got %b exp 0", both); else passed++;
  endtask

  task automatic test_rmw_clear_imm;
    int lat; logic [31:0] r; logic il, pv, pr;
    do_req(3'b111, 12'h300, 5'd8, 5'd1, 32'hFFFF_FFFF, lat, r, il, pv, pr);
    total++; if (wd_seen !== 32'h80) $display("FAIL rci_wdata got %h exp 80", wd_seen); else passed++;
    total++; if (r !== 32'h88) $display("FAIL rci_rdata got %h exp 88", r); else passed++;
    total++; if (lat !== 4) $display("FAIL rci_latency got %0d exp 4", lat); else passed++;
  endtask

  task automatic test_read_only_space;
    int lat; logic [31:0] r; logic il, pv, pr;
    do_req(3'b010, 12'hF11, 5'd0, 5'd1, 32'h0, lat, r, il, pv, pr);
    total++; if (il !== 1'b0 || r !== 32'h5) $display("FAIL f11_read got %h/%b exp 5/0", r, il); else passed++;
    total++; if (lat !== 3 || nwr !== 0) $display("FAIL f11_read_shape got lat=%0d wr=%0d exp 3/0", lat, nwr); else passed++;
    do_req(3'b001, 12'hF11, 5'd1, 5'd1, 32'h1234, lat, r, il, pv, pr);
    total++; if (il !== 1'b1 || r !== 32'h0) $display("FAIL f11_write got %h/%b exp 0/1", r, il); else passed++;
    total++; if (lat !== 1 || nrd !== 0 || nwr !== 0) $display("FAIL f11_write_shape got lat=%0d rd=%0d wr=%0d exp 1/0/0", lat, nrd, nwr); else passed++;
    do_req(3'b010, 12'h7C0, 5'd0, 5'd1, 32'h0, lat, r, il, pv, pr);
    total++; if (il !== 1'b1 || lat !== 1 || nrd !== 0) $display("FAIL bad_addr got ill=%b lat=%0d rd=%0d exp 1/1/0", il, lat, nrd); else passed++;
    do_req(3'b100, 12'h300, 5'd0, 5'd1, 32'h0, lat, r, il, pv, pr);
    total++; if (il !== 1'b1 || lat !== 1 || nrd + nwr !== 0) $display("FAIL bad_funct3 got ill=%b lat=%0d strobes=%0d exp 1/1/0", il, lat, nrd + nwr); else passed++;
  endtask

  task automatic test_backpressure;
    req_valid_i = 1'b1; req_funct3_i = 3'b010; req_csr_i = 12'h304;
    req_rs1_idx_i = 5'd0; req_rd_idx_i = 5'd2; req_rs1_data_i = 32'h0; rsp_ready_i = 1'b0;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    total++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h88) $display("FAIL bp_first got %b/%h exp 1/88", rsp_valid_o, rsp_rdata_o); else passed++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      total++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h88 || rsp_illegal_o !== 1'b0) $display("FAIL bp_hold%0d got %b/%h/%b exp 1/88/0", i, rsp_valid_o, rsp_rdata_o, rsp_illegal_o); else passed++;
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    total++; if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) $display("FAIL bp_release got valid=%b ready=%b exp 0/1", rsp_valid_o, req_ready_o); else passed++;
  endtask

  task automatic test_reset_mid_write;
    int lat; logic [31:0] r; logic il, pv, pr;
    req_valid_i = 1'b1; req_funct3_i = 3'b001; req_csr_i = 12'h306;
    req_rs1_idx_i = 5'd1; req_rd_idx_i = 5'd0; req_rs1_data_i = 32'hDEAD; rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    total++; if (csr_en_write_o !== 1'b1) $display("FAIL rw_in_write got %b exp 1", csr_en_write_o); else passed++;
    #2 rst_i = 1'b1;
    #1;
    total++; if (csr_en_write_o !== 1'b0 || rsp_valid_o !== 1'b0) $display("FAIL rw_async got wr=%b valid=%b exp 0/0", csr_en_write_o, rsp_valid_o); else passed++;
    total++; if (req_ready_o !== 1'b0) $display("FAIL rw_ready_in_rst got %b exp 0", req_ready_o); else passed++;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    total++; if (req_ready_o !== 1'b1) $display("FAIL rw_ready_after got %b exp 1", req_ready_o); else passed++;
    total++; if (mem[12'h306] !== 32'h0) $display("FAIL rw_aborted got %h exp 0", mem[12'h306]); else passed++;
    do_req(3'b001, 12'h306, 5'd1, 5'd1, 32'h1234, lat, r, il, pv, pr);
    total++; if (lat !== 4 || r !== 32'h0 || il !== 1'b0) $display("FAIL rw_after got lat=%0d r=%h ill=%b exp 4/0/0", lat, r, il); else passed++;
    total++; if (mem[12'h306] !== 32'h1234) $display("FAIL rw_after_reg got %h exp 1234", mem[12'h306]); else passed++;
  endtask

  task automatic test_back_to_back;
    int lat; logic [31:0] r; logic il, pv, pr;
    do_req(3'b001, 12'h341, 5'd1, 5'd0, 32'hA5, lat, r, il, pv, pr);
    total++; if (pv !== 1'b0 || pr !== 1'b1) $display("FAIL b2b_one_cycle got valid=%b ready=%b exp 0/1", pv, pr); else passed++;
    do_req(3'b010, 12'h341, 5'd0, 5'd5, 32'h0, lat, r, il, pv, pr);
    total++; if (lat !== 3 || r !== 32'hA5) $display("FAIL b2b_second got lat=%0d r=%h exp 3/a5", lat, r); else passed++;
    do_req(3'b101, 12'h342, 5'd31, 5'd0, 32'h0, lat, r, il, pv, pr);
    total++; if (lat !== 2 || wd_seen !== 32'h1F || nrd !== 0) $display("FAIL b2b_rwi got lat=%0d wd=%h rd=%0d exp 2/1f/0", lat, wd_seen, nrd); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] <= '0;
    mem[12'h304] <= 32'h8;
    mem[12'h300] <= 32'h88;
    mem[12'hF11] <= 32'h5;
    test_reset;
    test_write_only;
    test_rmw_set;
    test_rmw_clear_imm;
    test_read_only_space;
    test_backpressure;
    test_reset_mid_write;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
